// File: rtl/axi4_awch_sender_buf.sv
// Buffered AXI4 write-address sender: accepts or drops slave-side AWs based on the
// translation decision, queues accepted AWs and drives a registered master AW channel.
module axi4_awch_sender_buf #(
    parameter int C_AXI_ADDR_WIDTH  = 32,
    parameter int C_AXI_ID_WIDTH    = 4,
    parameter int C_AXI_USER_WIDTH  = 4,
    parameter int C_FIFO_DEPTH      = 4,
    parameter int C_MAX_OUTSTANDING = 8,
    parameter int C_CNT_WIDTH       = 16,
    localparam int OUT_W = $clog2(C_MAX_OUTSTANDING + 1)
) (
    input  logic                        axi4_aclk,
    input  logic                        axi4_arst,
    input  logic                        trans_accept,
    input  logic                        trans_drop,
    input  logic                        b_done,
    output logic                        trans_sent,
    output logic                        trans_dropped,
    output logic [OUT_W-1:0]            outstanding,
    output logic [C_CNT_WIDTH-1:0]      drop_count,
    input  logic [C_AXI_ID_WIDTH-1:0]   s_axi4_awid,
    input  logic [C_AXI_ADDR_WIDTH-1:0] s_axi4_awaddr,
    input  logic                        s_axi4_awvalid,
    output logic                        s_axi4_awready,
    input  logic [7:0]                  s_axi4_awlen,
    input  logic [2:0]                  s_axi4_awsize,
    input  logic [1:0]                  s_axi4_awburst,
    input  logic                        s_axi4_awlock,
    input  logic [2:0]                  s_axi4_awprot,
    input  logic [3:0]                  s_axi4_awcache,
    input  logic [3:0]                  s_axi4_awregion,
    input  logic [3:0]                  s_axi4_awqos,
    input  logic [C_AXI_USER_WIDTH-1:0] s_axi4_awuser,
    output logic [C_AXI_ID_WIDTH-1:0]   m_axi4_awid,
    output logic [C_AXI_ADDR_WIDTH-1:0] m_axi4_awaddr,
    output logic                        m_axi4_awvalid,
    input  logic                        m_axi4_awready,
    output logic [7:0]                  m_axi4_awlen,
    output logic [2:0]                  m_axi4_awsize,
    output logic [1:0]                  m_axi4_awburst,
    output logic                        m_axi4_awlock,
    output logic [2:0]                  m_axi4_awprot,
    output logic [3:0]                  m_axi4_awcache,
    output logic [3:0]                  m_axi4_awregion,
    output logic [3:0]                  m_axi4_awqos,
    output logic [C_AXI_USER_WIDTH-1:0] m_axi4_awuser
);
    localparam int PTR_W = (C_FIFO_DEPTH > 1) ? $clog2(C_FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(C_FIFO_DEPTH + 1);

    typedef struct packed {
        logic [C_AXI_ID_WIDTH-1:0]   id;
        logic [C_AXI_ADDR_WIDTH-1:0] addr;
        logic [7:0]                  len;
        logic [2:0]                  size;
        logic [1:0]                  burst;
        logic                        lock;
        logic [2:0]                  prot;
        logic [3:0]                  cache;
        logic [3:0]                  region;
        logic [3:0]                  qos;
        logic [C_AXI_USER_WIDTH-1:0] user;
    } aw_t;

    typedef enum logic {IDLE, WAIT} state_t;

    state_t            state, state_n;
    aw_t               mem [C_FIFO_DEPTH];
    aw_t               s_pay, head;
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count, count_n;
    logic              valid_q, push, pop, space;

    assign s_pay = '{s_axi4_awid, s_axi4_awaddr, s_axi4_awlen, s_axi4_awsize, s_axi4_awburst,
                     s_axi4_awlock, s_axi4_awprot, s_axi4_awcache, s_axi4_awregion,
                     s_axi4_awqos, s_axi4_awuser};

    // Space uses registered state only, so a same-cycle pop or b_done never opens a slot.
    assign space = (count != CNT_W'(C_FIFO_DEPTH)) && (outstanding < OUT_W'(C_MAX_OUTSTANDING));
    assign pop   = valid_q & m_axi4_awready;

    always_comb begin
        state_n        = state;
        s_axi4_awready = 1'b0;
        trans_sent     = 1'b0;
        trans_dropped  = 1'b0;
        push           = 1'b0;
        if (!axi4_arst && s_axi4_awvalid) begin
            if (trans_drop) begin
                s_axi4_awready = 1'b1;
                trans_sent     = 1'b1;
                trans_dropped  = 1'b1;
                state_n        = IDLE;
            end else if (trans_accept || state == WAIT) begin
                if (space) begin
                    s_axi4_awready = 1'b1;
                    trans_sent     = 1'b1;
                    push           = 1'b1;
                    state_n        = IDLE;
                end else begin
                    state_n = WAIT;
                end
            end
        end
    end

    always_comb begin
        count_n = count;
        if (push && !pop)      count_n = count + CNT_W'(1);
        else if (!push && pop) count_n = count - CNT_W'(1);
    end

    always_ff @(posedge axi4_aclk) begin
        if (axi4_arst) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            valid_q     <= 1'b0;
            outstanding <= '0;
            drop_count  <= '0;
        end else begin
            state   <= state_n;
            count   <= count_n;
            valid_q <= (count_n != '0);
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !b_done)
                outstanding <= outstanding + OUT_W'(1);
            else if (!push && b_done && outstanding != '0)
                outstanding <= outstanding - OUT_W'(1);
            if (trans_dropped && drop_count != '1)
                drop_count <= drop_count + C_CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge axi4_aclk) begin
        if (push) mem[wr_ptr] <= s_pay;
    end

    // Head entry is a register read; it only changes on the edge that pops it.
    assign head            = mem[rd_ptr];
    assign m_axi4_awvalid  = valid_q;
    assign m_axi4_awid     = head.id;
    assign m_axi4_awaddr   = head.addr;
    assign m_axi4_awlen    = head.len;
    assign m_axi4_awsize   = head.size;
    assign m_axi4_awburst  = head.burst;
    assign m_axi4_awlock   = head.lock;
    assign m_axi4_awprot   = head.prot;
    assign m_axi4_awcache  = head.cache;
    assign m_axi4_awregion = head.region;
    assign m_axi4_awqos    = head.qos;
    assign m_axi4_awuser   = head.user;
endmodule

// File: tb/tb_axi4_awch_sender_buf.sv
// Bench for axi4_awch_sender_buf: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_axi4_awch_sender_buf;
    localparam int AW = 32, IW = 4, UW = 4, DEPTH = 4, MAXO = 2, CW = 16;
    localparam int OW = $clog2(MAXO + 1);
    localparam int PW = IW + AW + 8 + 3 + 2 + 1 + 3 + 4 + 4 + 4 + UW;

    logic clk = 0, rst = 1;
    logic trans_accept = 0, trans_drop = 0, b_done = 0;
    logic trans_sent, trans_dropped;
    logic [OW-1:0] outstanding;
    logic [CW-1:0] drop_count;
    logic [IW-1:0] s_id = 0, m_id;
    logic [AW-1:0] s_addr = 0, m_addr;
    logic s_valid = 0, s_ready, m_valid, m_ready = 0;
    logic [7:0] s_len = 0, m_len;
    logic [2:0] s_size = 0, m_size, s_prot = 0, m_prot;
    logic [1:0] s_burst = 0, m_burst;
    logic s_lock = 0, m_lock;
    logic [3:0] s_cache = 0, m_cache, s_region = 0, m_region, s_qos = 0, m_qos;
    logic [UW-1:0] s_user = 0, m_user;

    int n_chk = 0, n_pass = 0;

    axi4_awch_sender_buf #(
        .C_AXI_ADDR_WIDTH(AW), .C_AXI_ID_WIDTH(IW), .C_AXI_USER_WIDTH(UW),
        .C_FIFO_DEPTH(DEPTH), .C_MAX_OUTSTANDING(MAXO), .C_CNT_WIDTH(CW)
    ) dut (
        .axi4_aclk(clk), .axi4_arst(rst),
        .trans_accept(trans_accept), .trans_drop(trans_drop), .b_done(b_done),
        .trans_sent(trans_sent), .trans_dropped(trans_dropped),
        .outstanding(outstanding), .drop_count(drop_count),
        .s_axi4_awid(s_id), .s_axi4_awaddr(s_addr), .s_axi4_awvalid(s_valid),
        .s_axi4_awready(s_ready), .s_axi4_awlen(s_len), .s_axi4_awsize(s_size),
        .s_axi4_awburst(s_burst), .s_axi4_awlock(s_lock), .s_axi4_awprot(s_prot),
        .s_axi4_awcache(s_cache), .s_axi4_awregion(s_region), .s_axi4_awqos(s_qos),
        .s_axi4_awuser(s_user),
        .m_axi4_awid(m_id), .m_axi4_awaddr(m_addr), .m_axi4_awvalid(m_valid),
        .m_axi4_awready(m_ready), .m_axi4_awlen(m_len), .m_axi4_awsize(m_size),
        .m_axi4_awburst(m_burst), .m_axi4_awlock(m_lock), .m_axi4_awprot(m_prot),
        .m_axi4_awcache(m_cache), .m_axi4_awregion(m_region), .m_axi4_awqos(m_qos),
        .m_axi4_awuser(m_user)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    wire [PW-1:0] s_pay = {s_id, s_addr, s_len, s_size, s_burst, s_lock, s_prot,
                           s_cache, s_region, s_qos, s_user};
    wire [PW-1:0] m_pay = {m_id, m_addr, m_len, m_size, m_burst, m_lock, m_prot,
                           m_cache, m_region, m_qos, m_user};

    // Reference model: queue of payloads, integer counters, one pending-accept flag.
    logic [PW-1:0] mq[$];
    int  m_out = 0, m_drops = 0;
    bit  m_pend = 0, mok = 0;
    bit  e_rdy, e_drop, e_push, e_pop, e_stall;

    always begin
        @(negedge clk);
        e_rdy = 0; e_drop = 0; e_push = 0; e_pop = 0; e_stall = 0;
        if (mok) begin
            if (!rst && s_valid) begin
                if (trans_drop) begin e_rdy = 1; e_drop = 1; end
                else if (trans_accept || m_pend) begin
                    if (mq.size() < DEPTH && m_out < MAXO) begin e_rdy = 1; e_push = 1; end
                    else e_stall = 1;
                end
            end
            e_pop = (mq.size() != 0) && m_ready;
            chk("s_awready", s_ready, e_rdy);
            chk("trans_sent", trans_sent, e_rdy);
            chk("trans_dropped", trans_dropped, e_drop);
            chk("m_awvalid", m_valid, mq.size() != 0);
            if (mq.size() != 0) chk("m_payload", m_pay, mq[0]);
            chk("outstanding", outstanding, m_out);
            chk("drop_count", drop_count, m_drops);
        end
        @(posedge clk);
        if (rst) begin
            mq.delete(); m_out = 0; m_drops = 0; m_pend = 0; mok = 1;
        end else if (mok) begin
            if (e_pop) void'(mq.pop_front());
            if (e_push) mq.push_back(s_pay);
            if (e_push && b_done) ;
            else if (e_push) m_out++;
            else if (b_done && m_out > 0) m_out--;
            if (e_drop && m_drops < (1 << CW) - 1) m_drops++;
            if (e_stall) m_pend = 1;
            else if (e_rdy) m_pend = 0;
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_aw(input logic [AW-1:0] a, input logic [IW-1:0] id);
        s_addr = a; s_id = id; s_len = a[7:0] ^ 8'h5a; s_size = a[2:0]; s_burst = 2'b01;
        s_lock = a[0]; s_prot = a[5:3]; s_cache = a[3:0]; s_region = id; s_qos = ~id;
        s_user = a[11:8];
    endtask

    initial begin
        cyc(2);
        rst = 0;
        #1;
        chk("rst_m_awvalid", m_valid, 0);
        chk("rst_outstanding", outstanding, 0);
        chk("rst_drop_count", drop_count, 0);
        chk("rst_s_awready", s_ready, 0);

        // single accept
        set_aw(32'h1000_0040, 4'd3); s_valid = 1; trans_accept = 1; #1;
        chk("sa_awready_c0", s_ready, 1);
        chk("sa_sent_c0", trans_sent, 1);
        chk("sa_mvalid_c0", m_valid, 0);
        cyc(); s_valid = 0; trans_accept = 0; #1;
        chk("sa_sent_c1", trans_sent, 0);
        chk("sa_mvalid_c1", m_valid, 1);
        chk("sa_addr", m_addr, 32'h1000_0040);
        chk("sa_id", m_id, 3);
        cyc(2);
        chk("sa_hold", m_valid, 1);
        m_ready = 1; cyc(); m_ready = 0; #1;
        chk("sa_popped", m_valid, 0);
        chk("sa_outst", outstanding, 1);
        b_done = 1; cyc(); b_done = 0; #1;
        chk("bd_outst0", outstanding, 0);
        b_done = 1; cyc(); b_done = 0; #1;
        chk("bd_at_zero", outstanding, 0);

        // drop priority
        set_aw(32'h2000_0000, 4'd7); s_valid = 1; trans_accept = 1; trans_drop = 1; #1;
        chk("dp_awready", s_ready, 1);
        chk("dp_dropped", trans_dropped, 1);
        cyc(); s_valid = 0; trans_accept = 0; trans_drop = 0; #1;
        chk("dp_count", drop_count, 1);
        chk("dp_no_mvalid", m_valid, 0);

        // FIFO full and WAIT; b_done held high keeps outstanding at 0
        b_done = 1;
        for (int i = 1; i <= 4; i++) begin
            set_aw(AW'(i), IW'(i)); s_valid = 1; trans_accept = 1; cyc();
        end
        set_aw(32'd5, 4'd5); #1;
        chk("ff_full_stall", s_ready, 0);
        cyc(); trans_accept = 0; #1;
        chk("ff_wait_stall", s_ready, 0);
        chk("ff_head1", m_addr, 1);
        m_ready = 1; #1;
        chk("ff_pop_no_space", s_ready, 0);
        cyc(); m_ready = 0; #1;
        chk("ff_wait_push", s_ready, 1);
        cyc(); s_valid = 0; b_done = 0;
        m_ready = 1;
        for (int i = 2; i <= 5; i++) begin
            #1; chk("ff_order", m_addr, i); cyc();
        end
        #1; chk("ff_drained", m_valid, 0);

        // outstanding limit of 2
        for (int i = 0; i < 2; i++) begin
            set_aw(32'hA0 + i, 4'd1); s_valid = 1; trans_accept = 1; cyc();
        end
        set_aw(32'hA2, 4'd2); #1;
        chk("ol_outst2", outstanding, 2);
        chk("ol_stall", s_ready, 0);
        cyc(); trans_accept = 0; b_done = 1; #1;
        chk("ol_bdone_no_space", s_ready, 0);
        cyc(); b_done = 0; #1;
        chk("ol_third_accept", s_ready, 1);
        cyc(); s_valid = 0;
        b_done = 1; cyc(); b_done = 0;
        set_aw(32'hA3, 4'd3); s_valid = 1; trans_accept = 1; b_done = 1; #1;
        chk("ol_push_bd_rdy", s_ready, 1);
        cyc(); s_valid = 0; trans_accept = 0; b_done = 0; #1;
        chk("ol_unchanged", outstanding, 1);
        b_done = 1; cyc(); b_done = 0;

        // reset mid-operation
        m_ready = 0;
        for (int i = 0; i < 3; i++) begin
            set_aw(32'hC0 + i, 4'd4); s_valid = 1;
            trans_accept = (i != 2); trans_drop = (i == 2); cyc();
        end
        s_valid = 0; trans_accept = 0; trans_drop = 0;
        rst = 1; cyc(); rst = 0; #1;
        chk("rm_mvalid", m_valid, 0);
        chk("rm_outst", outstanding, 0);
        chk("rm_drops", drop_count, 0);
        set_aw(32'h1000_0040, 4'd3); s_valid = 1; trans_accept = 1; #1;
        chk("rm_awready", s_ready, 1);
        cyc(); s_valid = 0; trans_accept = 0; #1;
        chk("rm_mvalid_c1", m_valid, 1);
        chk("rm_addr", m_addr, 32'h1000_0040);

        // drop counter saturation
        m_ready = 1; s_valid = 1; trans_drop = 1;
        cyc(65535);
        chk("sat_reach", drop_count, 16'hFFFF);
        cyc(5);
        chk("sat_hold", drop_count, 16'hFFFF);
        s_valid = 0; trans_drop = 0;
        cyc(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
